lsu_unit: RTL and testbench
===========================

# lsu_unit

Load/store unit that drives the word-addressed data memory on behalf of the execute stage. Accepts one load or store request at a time, generates byte enables and lane-aligned write data, collects read data, and returns sign/zero-extended load results. Lives between the ALU/control path and the data memory port. Owns all RV32I sub-word formatting, so the memory only sees word accesses with byte enables.

## Interface
- DM_ADDRESS, 9, word-index width of the data memory
- DATA_W, 32, data width (fixed at 32; other values unsupported)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  instruction bits 14:12 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address from ALU
- req_wdata  in  32  store data (rs2)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result (0 for stores/errors)
- resp_err  out  1  illegal funct3 or unsupported misaligned access
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe
- mem_addr  out  DM_ADDRESS  word index
- mem_be  out  4  byte enables, bit i = bits 8i+7:8i
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  read word, valid when mem_ack high
- mem_ack  in  1  access complete this cycle

## Operation
- States: IDLE, ACC0, ACC1, RESP. req_ready = (state == IDLE).
- IDLE: on req_valid && req_ready latch request; offset o = req_addr[1:0], word w = req_addr[DM_ADDRESS+1:2]; size 1/2/4 bytes from funct3[1:0]. Legal funct3: loads 000,001,010,100,101; stores 000,001,010. Illegal -> RESP with resp_err=1, no memory access.
- Crossing = o + size > 4. Non-crossing -> ACC0 only; crossing -> ACC0 then ACC1 (see Configuration).
- Byte-enable mask m = ((1<<size)-1) << o (8 bits). ACC0: mem_addr=w, mem_be=m[3:0]. ACC1: mem_addr=(w+1) mod 2^DM_ADDRESS, mem_be=m[7:4].
- Write data: 64-bit s = req_wdata << 8*o; ACC0 drives s[31:0], ACC1 drives s[63:32]. mem_we=req_we in both.
- Loads: capture mem_rdata on ack into lo (ACC0) / hi (ACC1); r = {hi,lo} >> 8*o; extend r per funct3 (LB/LH sign, LBU/LHU zero, LW none).
- ACCx: mem_req held high, address/be/data stable, until mem_ack; then advance. RESP: resp_valid=1 for one cycle, -> IDLE.
- Upper req_addr bits above DM_ADDRESS+1 ignored.

## Timing
- Reset: state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- mem_ack may arrive in the first mem_req cycle. Request accepted cycle N -> ACC0 at N+1; zero-wait ack -> resp_valid at N+2 (single) or N+3 (split). Each wait cycle adds one.
- mem_req, mem_we, mem_be are 0 outside ACC0/ACC1; mem_ack outside ACCx ignored.
- resp_rdata/resp_err valid only with resp_valid; held until next response.
- No new request accepted in the RESP cycle; back-to-back throughput is one request per 3 cycles minimum.
- rst_n low mid-access aborts immediately: mem_req drops asynchronously, no response issued.
- Split access wraps word index at 2^DM_ADDRESS-1 -> 0.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: crossing accesses split into two memory accesses as above; resp_err=0.
- Undefined: crossing accesses complete in RESP with resp_err=1, resp_rdata=0, no mem_req issued; ACC1 unreachable. Non-crossing misaligned (e.g. LB at o=3, LH at o=2) still legal.

## Test plan
- Reset mid-ACC0 (mem_ack held 0) -> mem_req=0 immediately, req_ready=1, no resp_valid.
- SB addr 0x0000_0006 data 0x0000_00A5 -> one access, mem_addr=1, mem_be=0100, mem_wdata[23:16]=0xA5.
- Word 2 = 0x8077_0000; LH addr 0x0A -> resp_rdata=0xFFFF_8077; LHU addr 0x0A -> 0x0000_8077; zero-wait resp_valid 2 cycles after accept.
- SW 0x1122_3344 at addr 0x0000_0003, macro on -> ACC0 mem_addr=0, be=1000, wdata=0x4400_0000; ACC1 mem_addr=1, be=0111, wdata=0x0011_2233; readback LW addr 3 -> 0x1122_3344.
- Same SW, macro off -> resp_err=1, no mem_req; load funct3=011 -> resp_err=1 regardless of macro.
- LW at addr 4*(2^9-1)+2 with macro on -> second access mem_addr=0 (wrap); 3 wait cycles on each ack -> resp_valid exactly 9 cycles after accept.

Source files
------------

// File: rtl/lsu_unit.sv
// Load/store unit: formats RV32I sub-word accesses into word accesses with byte enables.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two memory beats.
module lsu_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  state_t state;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] r);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = r[7:0];
    h = r[15:0];
    case (f3)
      3'b000:  load_ext = 32'(b);
      3'b001:  load_ext = 32'(h);
      3'b100:  load_ext = {24'd0, r[7:0]};
      3'b101:  load_ext = {16'd0, r[15:0]};
      default: load_ext = r;
    endcase
  endfunction

  logic [1:0]  off_in;
  logic [2:0]  size_in;
  logic        legal_in;
  logic        cross_in;
  logic [7:0]  mask_in;
  logic [63:0] sdata_in;
  logic        unused_addr;

  assign off_in      = req_addr[1:0];
  assign unused_addr = ^req_addr[31:DM_ADDRESS+2];

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   begin size_in = 3'd1; mask_in = 8'h01; end
      2'b01:   begin size_in = 3'd2; mask_in = 8'h03; end
      default: begin size_in = 3'd4; mask_in = 8'h0F; end
    endcase
    mask_in  = mask_in << off_in;
    cross_in = (3'(off_in) + size_in) > 3'd4;
    sdata_in = {32'd0, req_wdata} << {off_in, 3'b000};
    if (req_we)
      legal_in = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else
      legal_in = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
  end

  // Request latch: captured once per accepted request
  logic [1:0]  off_p0;
  logic        we_p0;
  logic [2:0]  f3_p0;
  logic        cross_p0;
  logic [3:0]  be_hi_p0;
  logic [31:0] wdata_hi_p0;
  logic [31:0] lo_p1;
  logic [31:0] rd_word;

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      off_p0      <= off_in;
      we_p0       <= req_we;
      f3_p0       <= req_funct3;
      cross_p0    <= cross_in;
      be_hi_p0    <= mask_in[7:4];
      wdata_hi_p0 <= sdata_in[63:32];
    end
    if (state == ACC0 && mem_ack)
      lo_p1 <= mem_rdata;
  end

  // In ACC1 the low beat is already in lo_p1; a single beat shifts the fresh word alone
  always_comb begin
    if (state == ACC1)
      rd_word = 32'({mem_rdata, lo_p1} >> {off_p0, 3'b000});
    else
      rd_word = 32'({32'd0, mem_rdata} >> {off_p0, 3'b000});
  end

  assign req_ready = (state == IDLE);

  // Control FSM with registered memory-port and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'd0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (!legal_in || (cross_in && !SPLIT_EN)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= ACC0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= req_addr[DM_ADDRESS+1:2];
              mem_be    <= mask_in[3:0];
              mem_wdata <= sdata_in[31:0];
            end
          end
        end
        ACC0, ACC1: begin
          if (mem_ack) begin
            if (state == ACC0 && cross_p0) begin
              state     <= ACC1;
              mem_addr  <= mem_addr + 1'b1;
              mem_be    <= be_hi_p0;
              mem_wdata <= wdata_hi_p0;
            end else begin
              state      <= RESP;
              mem_req    <= 1'b0;
              mem_we     <= 1'b0;
              mem_be     <= 4'd0;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= we_p0 ? '0 : load_ext(f3_p0, rd_word);
            end
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// Directed self-checking bench for lsu_unit with a wait-state programmable word memory.
module tb_lsu_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  int passed = 0;
  int total = 0;

  logic [31:0] mem [512];
  int wait_cycles = 0;
  int wcnt = 0;
  int acc_n = 0;
  int mreq_cycles = 0;
  logic [8:0]  acc_addr [8];
  logic [3:0]  acc_be [8];
  logic [31:0] acc_wdata [8];

  lsu_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Memory responder: ack after wait_cycles stall cycles per beat
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else begin
      mreq_cycles++;
      if (mem_ack) wcnt = 0;
      if (wcnt >= wait_cycles) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we)
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
        acc_addr[acc_n % 8] = mem_addr;
        acc_be[acc_n % 8] = mem_be;
        acc_wdata[acc_n % 8] = mem_wdata;
        acc_n++;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 99; rd = 'x; err = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = n; rd = resp_rdata; err = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", req_ready); else passed++;
    total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", resp_valid); else passed++;
    total++; if ({mem_req, mem_we, mem_be} !== 6'd0) $display("FAIL rst_mem_ctrl got %b want 0", {mem_req, mem_we, mem_be}); else passed++;
    total++; if ({mem_addr, mem_wdata, resp_rdata, resp_err} !== 74'd0)
      $display("FAIL rst_data got %h want 0", {mem_addr, mem_wdata, resp_rdata, resp_err}); else passed++;
  endtask

  task automatic test_reset_mid_access();
    int seen;
    seen = 0;
    wait_cycles = 20;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    total++; if (mem_req !== 1'b1) $display("FAIL midrst_req_before got %b want 1", mem_req); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) $display("FAIL midrst_req_drop got %b want 0", mem_req); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", req_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    total++; if (seen !== 0) $display("FAIL midrst_no_resp got %0d responses want 0", seen); else passed++;
    wait_cycles = 0;
  endtask

  task automatic preload();
    logic [31:0] rd; logic err; int lat;
    do_req(1'b1, 3'b010, 32'h0,   32'h0,         rd, err, lat);
    do_req(1'b1, 3'b010, 32'h4,   32'h0,         rd, err, lat);
    do_req(1'b1, 3'b010, 32'h8,   32'h8077_0000, rd, err, lat);
    do_req(1'b1, 3'b010, 32'hC,   32'hC100_0000, rd, err, lat);
  endtask

  task automatic test_sb();
    logic [31:0] rd; logic err; int lat; int base;
    base = acc_n;
    do_req(1'b1, 3'b000, 32'h6, 32'h0000_00A5, rd, err, lat);
    total++; if (acc_n - base !== 1) $display("FAIL sb_beats got %0d want 1", acc_n - base); else passed++;
    total++; if (acc_addr[base % 8] !== 9'd1) $display("FAIL sb_addr got %0d want 1", acc_addr[base % 8]); else passed++;
    total++; if (acc_be[base % 8] !== 4'b0100) $display("FAIL sb_be got %b want 0100", acc_be[base % 8]); else passed++;
    total++; if (acc_wdata[base % 8][23:16] !== 8'hA5) $display("FAIL sb_wdata got %h want a5", acc_wdata[base % 8][23:16]); else passed++;
    total++; if (mem[1] !== 32'h00A5_0000) $display("FAIL sb_mem got %h want 00a50000", mem[1]); else passed++;
    total++; if ({err, rd} !== 33'd0) $display("FAIL sb_resp got %h want 0", {err, rd}); else passed++;
    total++; if (lat !== 2) $display("FAIL sb_latency got %0d want 2", lat); else passed++;
  endtask

  task automatic test_load_ext();
    logic [31:0] rd; logic err; int lat;
    do_req(1'b0, 3'b001, 32'h0A, 32'h0, rd, err, lat);
    total++; if (rd !== 32'hFFFF_8077) $display("FAIL lh got %h want ffff8077", rd); else passed++;
    total++; if (lat !== 2) $display("FAIL lh_latency got %0d want 2", lat); else passed++;
    do_req(1'b0, 3'b101, 32'h0A, 32'h0, rd, err, lat);
    total++; if (rd !== 32'h0000_8077) $display("FAIL lhu got %h want 00008077", rd); else passed++;
    do_req(1'b0, 3'b000, 32'h0B, 32'h0, rd, err, lat);
    total++; if (rd !== 32'hFFFF_FF80) $display("FAIL lb got %h want ffffff80", rd); else passed++;
    do_req(1'b0, 3'b100, 32'h0A, 32'h0, rd, err, lat);
    total++; if (rd !== 32'h0000_0077) $display("FAIL lbu got %h want 00000077", rd); else passed++;
    do_req(1'b0, 3'b010, 32'h08, 32'h0, rd, err, lat);
    total++; if (rd !== 32'h8077_0000) $display("FAIL lw got %h want 80770000", rd); else passed++;
    do_req(1'b0, 3'b000, 32'h0F, 32'h0, rd, err, lat);
    total++; if ({err, rd} !== {1'b0, 32'hFFFF_FFC1}) $display("FAIL lb_off3 got %h want 0ffffffc1", {err, rd}); else passed++;
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic err; int lat; int base; int mbase;
    base = acc_n; mbase = mreq_cycles;
    do_req(1'b1, 3'b010, 32'h3, 32'h1122_3344, rd, err, lat);
`ifdef LSU_MISALIGN_SPLIT_EN
    total++; if (acc_n - base !== 2) $display("FAIL sw_split_beats got %0d want 2", acc_n - base); else passed++;
    total++; if ({acc_addr[base % 8], acc_be[base % 8], acc_wdata[base % 8]} !== {9'd0, 4'b1000, 32'h4400_0000})
      $display("FAIL sw_split_acc0 got %h/%b/%h want 0/1000/44000000", acc_addr[base % 8], acc_be[base % 8], acc_wdata[base % 8]); else passed++;
    total++; if ({acc_addr[(base+1) % 8], acc_be[(base+1) % 8], acc_wdata[(base+1) % 8]} !== {9'd1, 4'b0111, 32'h0011_2233})
      $display("FAIL sw_split_acc1 got %h/%b/%h want 1/0111/00112233", acc_addr[(base+1) % 8], acc_be[(base+1) % 8], acc_wdata[(base+1) % 8]); else passed++;
    total++; if ({err, lat} !== {1'b0, 32'd3}) $display("FAIL sw_split_resp got err=%b lat=%0d want 0/3", err, lat); else passed++;
    do_req(1'b0, 3'b010, 32'h3, 32'h0, rd, err, lat);
    total++; if ({err, rd} !== {1'b0, 32'h1122_3344}) $display("FAIL lw_split got %h want 011223344", {err, rd}); else passed++;
`else
    total++; if ({err, rd} !== {1'b1, 32'h0}) $display("FAIL sw_cross_err got %h want 100000000", {err, rd}); else passed++;
    total++; if (mreq_cycles - mbase !== 0) $display("FAIL sw_cross_nomem got %0d req cycles want 0", mreq_cycles - mbase); else passed++;
    total++; if (lat !== 1) $display("FAIL sw_cross_latency got %0d want 1", lat); else passed++;
`endif
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic err; int lat; int mbase;
    mbase = mreq_cycles;
    do_req(1'b0, 3'b011, 32'h0, 32'h0, rd, err, lat);
    total++; if ({err, rd} !== {1'b1, 32'h0}) $display("FAIL ld011_err got %h want 100000000", {err, rd}); else passed++;
    total++; if (lat !== 1) $display("FAIL ld011_latency got %0d want 1", lat); else passed++;
    do_req(1'b1, 3'b100, 32'h0, 32'h0, rd, err, lat);
    total++; if (err !== 1'b1) $display("FAIL st100_err got %b want 1", err); else passed++;
    total++; if (mreq_cycles - mbase !== 0) $display("FAIL illegal_nomem got %0d req cycles want 0", mreq_cycles - mbase); else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic err; int lat; int base;
    do_req(1'b1, 3'b010, 32'h7FC, 32'hAABB_CCDD, rd, err, lat);
    do_req(1'b1, 3'b010, 32'h000, 32'h1122_3344, rd, err, lat);
    wait_cycles = 3;
    base = acc_n;
    do_req(1'b0, 3'b010, 32'hFFFF_F7FE, 32'h0, rd, err, lat);
    wait_cycles = 0;
`ifdef LSU_MISALIGN_SPLIT_EN
    total++; if ({err, rd} !== {1'b0, 32'h3344_AABB}) $display("FAIL wrap_data got %h want 03344aabb", {err, rd}); else passed++;
    total++; if ({acc_addr[base % 8], acc_addr[(base+1) % 8]} !== {9'd511, 9'd0})
      $display("FAIL wrap_addr got %0d,%0d want 511,0", acc_addr[base % 8], acc_addr[(base+1) % 8]); else passed++;
    total++; if (lat !== 9) $display("FAIL wrap_latency got %0d want 9", lat); else passed++;
`else
    total++; if ({err, rd} !== {1'b1, 32'h0}) $display("FAIL wrap_err got %h want 100000000", {err, rd}); else passed++;
    total++; if (acc_n - base !== 0) $display("FAIL wrap_nomem got %0d beats want 0", acc_n - base); else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int lat;
    do_req(1'b0, 3'b010, 32'h8, 32'h0, rd, err, lat);
    total++; if (req_ready !== 1'b0) $display("FAIL b2b_ready_in_resp got %b want 0", req_ready); else passed++;
    @(negedge clk);
    total++; if ({req_ready, resp_valid} !== 2'b10) $display("FAIL b2b_after_resp got %b want 10", {req_ready, resp_valid}); else passed++;
    total++; if (resp_rdata !== 32'h8077_0000) $display("FAIL b2b_hold got %h want 80770000", resp_rdata); else passed++;
    do_req(1'b0, 3'b101, 32'h8, 32'h0, rd, err, lat);
    total++; if ({rd, lat} !== {32'h0, 32'd2}) $display("FAIL b2b_second got %h lat %0d want 0 lat 2", rd, lat); else passed++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_reset_mid_access();
    preload();
    test_sb();
    test_load_ext();
    test_misaligned();
    test_illegal();
    test_wrap();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
